program_loader: RTL

- Serial-byte boot loader that fills the instruction ROM's backing storage before the CPU runs. It writes the same memory the fetch path reads.
- Accepts a framed byte stream from a UART receiver and assembles big-endian 32-bit words. Each word is written to consecutive word addresses starting at the text base 0x00400000.
- Holds the CPU while loading and reports completion or error.

---
 rtl/program_loader_pkg.sv | 28 ++
 rtl/program_loader_word_assembler.sv | 36 +++
 rtl/program_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the serial boot loader.
package program_loader_pkg;

  localparam int unsigned MEMORY_DEPTH   = 32;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_W          = 16;
  localparam int unsigned BCNT_W         = 2;
  localparam logic [DATA_WIDTH-1:0] TEXT_BASE = 32'h0040_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_e;

  // One program-memory write transaction.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } mem_wr_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Big-endian 4-byte word assembler: the 4th byte completes a word combinationally.
module program_loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [BYTE_W-1:0]     i_byte,
  output logic                  o_word_ready_c,
  output logic [DATA_WIDTH-1:0] o_word_c
);

  localparam int unsigned SHIFT_W = DATA_WIDTH - BYTE_W;

  logic [BCNT_W-1:0]  r_cnt;
  logic [SHIFT_W-1:0] r_shift;

  assign o_word_ready_c = i_valid && (r_cnt == BCNT_W'(BYTES_PER_WORD - 1));
  assign o_word_c       = {r_shift, i_byte};

  // Byte counter and shift register; counter wraps naturally after the 4th byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_valid) begin
      r_cnt   <= r_cnt + BCNT_W'(1);
      r_shift <= {r_shift[SHIFT_W-BYTE_W-1:0], i_byte};
    end
  end

endmodule

// File: rtl/program_loader.sv
// Serial-byte boot loader: parses a length/data/checksum frame and fills program memory.
module program_loader
  import program_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic                  ByteValid,
  input  logic [BYTE_W-1:0]     ByteData,
  output logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  CpuHold,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  state_e             r_state;
  state_e             w_next;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   w_len;
  logic [LEN_W-1:0]   w_len_full;
  logic [LEN_W-1:0]   r_index;
  logic [LEN_W-1:0]   w_index;
  logic [BYTE_W-1:0]  r_csum;
  logic [BYTE_W-1:0]  w_csum;
  logic               w_we;
  mem_wr_t            w_wr;
  logic               w_start_ok;
  logic               w_data_byte;
  logic               w_word_ready;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_start_ok  = Start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
  assign w_data_byte = ByteValid && (r_state == DATA);
  assign w_len_full  = {r_len[LEN_W-1:BYTE_W], ByteData};

  program_loader_word_assembler u_asm (
    .clk            (clk),
    .reset          (reset),
    .i_clear        (w_start_ok),
    .i_valid        (w_data_byte),
    .i_byte         (ByteData),
    .o_word_ready_c (w_word_ready),
    .o_word_c       (w_word)
  );

  // Next-state, counters, checksum and write-port values.
  always_comb begin
    w_next  = r_state;
    w_len   = r_len;
    w_index = r_index;
    w_csum  = r_csum;
    w_we    = 1'b0;
    w_wr    = '{addr: WriteAddress, data: WriteData};
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (Start) begin
          w_next  = LEN_HI;
          w_len   = '0;
          w_index = '0;
          w_csum  = '0;
          w_wr    = '{addr: TEXT_BASE, data: WriteData};
        end
      end
      LEN_HI: begin
        if (ByteValid) begin
          w_len  = {ByteData, BYTE_W'(0)};
          w_next = LEN_LO;
        end
      end
      LEN_LO: begin
        if (ByteValid) begin
          w_len = w_len_full;
          if (w_len_full > LEN_W'(MEMORY_DEPTH)) begin
            w_next = ERROR;
          end else if (w_len_full == '0) begin
            w_next = CHECK;
          end else begin
            w_next = DATA;
          end
        end
      end
      DATA: begin
        if (ByteValid) begin
          w_csum = r_csum ^ ByteData;
        end
        if (w_word_ready && (r_index < LEN_W'(MEMORY_DEPTH))) begin
          w_we    = 1'b1;
          w_wr    = '{addr: TEXT_BASE + DATA_WIDTH'({r_index, 2'b00}), data: w_word};
          w_index = r_index + LEN_W'(1);
          if (r_index == (r_len - LEN_W'(1))) begin
            w_next = CHECK;
          end
        end
      end
      CHECK: begin
        if (ByteValid) begin
          w_next = (ByteData == r_csum) ? DONE : ERROR;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_index      <= '0;
      r_csum       <= '0;
      WriteEnable  <= 1'b0;
      WriteAddress <= TEXT_BASE;
      WriteData    <= '0;
      CpuHold      <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Error        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_len        <= w_len;
      r_index      <= w_index;
      r_csum       <= w_csum;
      WriteEnable  <= w_we;
      WriteAddress <= w_wr.addr;
      WriteData    <= w_wr.data;
      CpuHold      <= (w_next != IDLE) && (w_next != DONE);
      Busy         <= (w_next == LEN_HI) || (w_next == LEN_LO) ||
                      (w_next == DATA)   || (w_next == CHECK);
      Done         <= (w_next == DONE);
      Error        <= (w_next == ERROR);
    end
  end

endmodule
